// File: rtl/tpu_pkg.sv
// Shared types and default sizing for the TPU run controller.
// State encoding, array geometry defaults, drain-length helper.
package tpu_pkg;

    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_NUM_PE_ROWS = 8;
    localparam int DEF_MAX_TILES   = 4;

    typedef enum logic [2:0] {
        IDLE,
        WFETCH,
        WLOAD,
        STREAM,
        DRAIN,
        DONE
    } tpu_run_state_t;

    // Cycles for the last activation row to ripple out of the array.
    function automatic int DEF_DRAIN_CYCLES(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/tpu_run_ctrl_addr_gen.sv
// Activation address generator: row counter, per-tile base, SRAM address.
// step loads sram_address from base+row, next_tile advances base by R.
module tpu_addr_gen
    import tpu_pkg::*;
#(
    parameter int AW = DEF_ADDRESSSIZE
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_i,
    input  logic          step_i,
    input  logic          next_tile_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] rows_i,
    output logic          last_row_o,
    output logic [AW-1:0] addr_o
);

    logic [AW-1:0] rows_q, rows_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   row_q, row_d;

    // Next-state for base, row and address; row runs one ahead of addr.
    always_comb begin
        rows_d = rows_q;
        base_d = base_q;
        addr_d = addr_q;
        row_d  = row_q;
        if (load_i) begin
            rows_d = rows_i;
            base_d = base_i;
            row_d  = '0;
        end else if (next_tile_i) begin
            base_d = base_q + rows_q;
            row_d  = '0;
        end else if (step_i) begin
            addr_d = base_q + row_q[AW-1:0];
            row_d  = row_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows_q <= '0;
            base_q <= '0;
            addr_q <= '0;
            row_q  <= '0;
        end else begin
            rows_q <= rows_d;
            base_q <= base_d;
            addr_q <= addr_d;
            row_q  <= row_d;
        end
    end

    assign last_row_o = (row_q == {1'b0, rows_q});
    assign addr_o     = addr_q;

endmodule

// File: rtl/tpu_run_ctrl.sv
// Run controller FSM: per tile pops FIFO, latches weights, streams, drains.
// Optional stall counter enabled by macro TPU_RUN_CTRL_PERF_EN.
module tpu_run_ctrl
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE  = DEF_ADDRESSSIZE,
    parameter int MATRIX_SIZE  = DEF_MATRIX_SIZE,
    parameter int NUM_PE_ROWS  = DEF_NUM_PE_ROWS,
    parameter int MAX_TILES    = DEF_MAX_TILES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES(NUM_PE_ROWS, MATRIX_SIZE),
    parameter int TW           = $clog2(MAX_TILES) + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] cfg_base_addr,
    input  logic [ADDRESSSIZE-1:0] cfg_num_rows,
    input  logic [TW-1:0]          cfg_num_tiles,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic [ADDRESSSIZE-1:0] sram_address,
    output logic                   valid_address,
    output logic                   addr_ctrl_en,
    output logic                   busy,
    output logic                   end_,
    output logic [15:0]            stall_cycles
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(MAX_TILES);

    tpu_run_state_t state_q, state_d;
    logic [TW-1:0]  tiles_q, tiles_d;
    logic [TW-1:0]  tile_q, tile_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           accept;
    logic           ag_load, ag_step, ag_next, ag_last;

    assign accept = (state_q == IDLE) && start;

    // Next-state and control decode; fifo_read_enable is the Mealy output.
    always_comb begin
        state_d          = state_q;
        tiles_d          = tiles_q;
        tile_d           = tile_q;
        drain_d          = drain_q;
        fifo_read_enable = 1'b0;
        we_rl            = 1'b0;
        valid_address    = 1'b0;
        end_             = 1'b0;
        ag_load          = 1'b0;
        ag_step          = 1'b0;
        ag_next          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ag_load = 1'b1;
                    tile_d  = '0;
                    tiles_d = (cfg_num_tiles > TMAX) ? TMAX : cfg_num_tiles;
                    if (cfg_num_tiles == '0 || cfg_num_rows == '0)
                        state_d = DONE;
                    else
                        state_d = WFETCH;
                end
            end
            WFETCH: begin
                fifo_read_enable = !fifo_empty;
                if (!fifo_empty) state_d = WLOAD;
            end
            WLOAD: begin
                we_rl   = 1'b1;
                ag_step = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                valid_address = 1'b1;
                if (ag_last) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    ag_step = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DLAST) begin
                    if (tile_q != tiles_q - TW'(1)) begin
                        tile_d  = tile_q + TW'(1);
                        ag_next = 1'b1;
                        state_d = WFETCH;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                end_    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, tile and drain registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            tiles_q <= '0;
            tile_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            tiles_q <= tiles_d;
            tile_q  <= tile_d;
            drain_q <= drain_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign addr_ctrl_en = busy;

    tpu_addr_gen #(
        .AW(ADDRESSSIZE)
    ) u_addr_gen (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (ag_load),
        .step_i     (ag_step),
        .next_tile_i(ag_next),
        .base_i     (cfg_base_addr),
        .rows_i     (cfg_num_rows),
        .last_row_o (ag_last),
        .addr_o     (sram_address)
    );

`ifdef TPU_RUN_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of FIFO-empty cycles spent waiting for weights.
    always_comb begin
        stall_d = stall_q;
        if (accept)
            stall_d = '0;
        else if (state_q == WFETCH && fifo_empty && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign stall_cycles  = 16'd0;
`endif

endmodule

// File: tb/tb_tpu_run_ctrl.sv
// Self-checking bench for tpu_run_ctrl: directed table, reset and
// randomized runs against a timeline model of the run sequence.
module tb_tpu_run_ctrl;

    localparam int AW   = 10;
    localparam int TW   = 3;
    localparam int DRN  = 15;
    localparam int MAXC = 512;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] cfg_base_addr;
    logic [AW-1:0] cfg_num_rows;
    logic [TW-1:0] cfg_num_tiles;
    logic          fifo_empty;
    logic          fifo_read_enable;
    logic          we_rl;
    logic [AW-1:0] sram_address;
    logic          valid_address;
    logic          addr_ctrl_en;
    logic          busy;
    logic          end_;
    logic [15:0]   stall_cycles;

    tpu_run_ctrl dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_num_rows    (cfg_num_rows),
        .cfg_num_tiles   (cfg_num_tiles),
        .fifo_empty      (fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .we_rl           (we_rl),
        .sram_address    (sram_address),
        .valid_address   (valid_address),
        .addr_ctrl_en    (addr_ctrl_en),
        .busy            (busy),
        .end_            (end_),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          fre;
        logic          we;
        logic          va;
        logic [AW-1:0] addr;
        logic          en;
        logic          bsy;
        logic          ace;
    } obs_t;

    typedef struct {
        int endc;
        int pops;
        int wes;
        int vals;
        int first;
        int last;
        int busyn;
        int stall;
    } res_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] rows;
        logic [TW-1:0] tiles;
        int            nstall;
        bit            chaos;
        int            endc;
        int            pops;
        int            vals;
        int            first;
        int            last;
    } vec_t;

    int            checks;
    int            failures;
    obs_t          expv[MAXC];
    bit            empty_sched[MAXC];
    int            mend;
    int            mstall;
    logic [AW-1:0] last_addr;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int perf(input int n);
`ifdef TPU_RUN_CTRL_PERF_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic void set_sched(input int n);
        for (int c = 0; c < MAXC; c++) empty_sched[c] = (c >= 1 && c <= n);
    endfunction

    // Timeline model: lay out each tile's phases cycle by cycle.
    function automatic void build(input logic [AW-1:0] base,
                                  input int rows, input int tiles);
        int            t;
        int            te;
        logic [AW-1:0] a;
        te = (tiles > 4) ? 4 : tiles;
        for (int c = 0; c < MAXC; c++) expv[c] = '0;
        mstall = 0;
        t = 1;
        if (te != 0 && rows != 0) begin
            for (int k = 0; k < te; k++) begin
                while (empty_sched[t]) begin
                    expv[t].bsy = 1'b1;
                    mstall++;
                    t++;
                end
                expv[t].fre = 1'b1;
                expv[t].bsy = 1'b1;
                t++;
                expv[t].we  = 1'b1;
                expv[t].bsy = 1'b1;
                t++;
                for (int r = 0; r < rows; r++) begin
                    expv[t].va   = 1'b1;
                    expv[t].addr = AW'(int'(base) + k * rows + r);
                    expv[t].bsy  = 1'b1;
                    t++;
                end
                for (int d = 0; d < DRN; d++) begin
                    expv[t].bsy = 1'b1;
                    t++;
                end
            end
        end
        expv[t].en  = 1'b1;
        expv[t].bsy = 1'b1;
        mend = t;
        a = last_addr;
        for (int c = 0; c <= mend + 1; c++) begin
            if (expv[c].va) a = expv[c].addr;
            else expv[c].addr = a;
            expv[c].ace = expv[c].bsy;
        end
        last_addr = a;
    endfunction

    // Drive one run from cycle 0 and compare every cycle with the model.
    task automatic run(input logic [AW-1:0] base, input logic [AW-1:0] rows,
                       input logic [TW-1:0] tiles, input bit chaos,
                       output res_t res);
        obs_t o;
        build(base, int'(rows), int'(tiles));
        res = '{-1, 0, 0, 0, -1, -1, 0, 0};
        for (int c = 0; c <= mend + 1; c++) begin
            @(posedge clk);
            #1;
            start         = (c == 0) || (chaos && expv[c].va);
            cfg_base_addr = base;
            cfg_num_rows  = rows;
            cfg_num_tiles = tiles;
            if (chaos && expv[c].va) begin
                cfg_base_addr = AW'($urandom);
                cfg_num_rows  = AW'($urandom_range(1, 40));
                cfg_num_tiles = TW'($urandom);
            end
            fifo_empty = empty_sched[c];
            @(negedge clk);
            o = {fifo_read_enable, we_rl, valid_address, sram_address,
                 end_, busy, addr_ctrl_en};
            chk($sformatf("cyc%0d", c), int'(o), int'(expv[c]));
            if (end_ && res.endc < 0) res.endc = c;
            res.pops  += int'(fifo_read_enable);
            res.wes   += int'(we_rl);
            res.vals  += int'(valid_address);
            res.busyn += int'(busy);
            if (valid_address) begin
                if (res.first < 0) res.first = int'(sram_address);
                res.last = int'(sram_address);
            end
        end
        res.stall = int'(stall_cycles);
        start = 1'b0;
        fifo_empty = 1'b0;
    endtask

    vec_t vt[7];
    res_t r;
    obs_t o;

    initial begin
        checks    = 0;
        failures  = 0;
        last_addr = '0;
        start     = 1'b0;
        fifo_empty    = 1'b0;
        cfg_base_addr = '0;
        cfg_num_rows  = '0;
        cfg_num_tiles = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        o = {fifo_read_enable, we_rl, valid_address, sram_address,
             end_, busy, addr_ctrl_en};
        chk("reset_outs", int'(o), 0);
        chk("reset_stall", int'(stall_cycles), 0);
        #19 rstn = 1'b1;

        vt[0] = '{10'h000, 10'd8, 3'd1, 0, 1'b0, 26, 1, 8, 'h000, 'h007};
        vt[1] = '{10'h3FC, 10'd8, 3'd2, 0, 1'b0, 51, 2, 16, 'h3FC, 'h00B};
        vt[2] = '{10'h000, 10'd8, 3'd1, 3, 1'b0, 29, 1, 8, 'h000, 'h007};
        vt[3] = '{10'h055, 10'd8, 3'd0, 0, 1'b0, 1, 0, 0, -1, -1};
        vt[4] = '{10'h055, 10'd0, 3'd3, 0, 1'b0, 1, 0, 0, -1, -1};
        vt[5] = '{10'h010, 10'd2, 3'd7, 0, 1'b0, 77, 4, 8, 'h010, 'h017};
        vt[6] = '{10'h020, 10'd8, 3'd1, 0, 1'b1, 26, 1, 8, 'h020, 'h027};

        foreach (vt[i]) begin
            set_sched(vt[i].nstall);
            run(vt[i].base, vt[i].rows, vt[i].tiles, vt[i].chaos, r);
            chk($sformatf("v%0d_end", i), r.endc, vt[i].endc);
            chk($sformatf("v%0d_pops", i), r.pops, vt[i].pops);
            chk($sformatf("v%0d_we", i), r.wes, vt[i].pops);
            chk($sformatf("v%0d_vals", i), r.vals, vt[i].vals);
            chk($sformatf("v%0d_first", i), r.first, vt[i].first);
            chk($sformatf("v%0d_last", i), r.last, vt[i].last);
            chk($sformatf("v%0d_busy", i), r.busyn, vt[i].endc);
            chk($sformatf("v%0d_stall", i), r.stall, perf(vt[i].nstall));
        end

        // Reset during DRAIN of tile 0 of a two-tile run.
        set_sched(0);
        @(posedge clk);
        #1;
        start         = 1'b1;
        cfg_base_addr = 10'h100;
        cfg_num_rows  = 10'd8;
        cfg_num_tiles = 3'd2;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("pre_rst_busy", int'(busy), 1);
        #2 rstn = 1'b0;
        #1;
        o = {fifo_read_enable, we_rl, valid_address, sram_address,
             end_, busy, addr_ctrl_en};
        chk("midrun_rst_outs", int'(o), 0);
        chk("midrun_rst_stall", int'(stall_cycles), 0);
        @(posedge clk);
        #3 rstn = 1'b1;
        last_addr = '0;
        run(vt[0].base, vt[0].rows, vt[0].tiles, 1'b0, r);
        chk("post_rst_end", r.endc, 26);
        chk("post_rst_pops", r.pops, 1);
        chk("post_rst_last", r.last, 7);

        // Randomized runs with random FIFO-empty stalls.
        for (int n = 0; n < 30; n++) begin
            logic [AW-1:0] b;
            logic [AW-1:0] rw;
            logic [TW-1:0] tl;
            b  = AW'($urandom);
            rw = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 6));
            tl = TW'($urandom_range(0, 7));
            for (int c = 0; c < MAXC; c++)
                empty_sched[c] = (c >= 1 && c < 300) &&
                                 ($urandom_range(0, 9) < 3);
            run(b, rw, tl, n[0], r);
            chk($sformatf("rnd%0d_stall", n), r.stall, perf(mstall));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
